// File: rtl/tt_um_mult.sv
// Sequencer for the ternary matrix-vector multiplier: collects x, runs compute/flush passes, streams y.
// Optional build macro SEQ_RELU_EN clamps negative results to zero as they are captured.
module tt_um_mult_seq #(
  parameter int InLen    = 14,
  parameter int OutLen   = 7,
  parameter int BitWidth = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_load_en,
  input  logic [2:0]            w_load_addr,
  input  logic [4*OutLen-1:0]   w_load_data,
  output logic                  w_drop,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BitWidth-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BitWidth-1:0]   out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  m_en,
  output logic [2:0]            m_row,
  output logic [2*BitWidth-1:0] m_vec,
  output logic [4*OutLen-1:0]   m_w,
  input  logic [BitWidth-1:0]   m_vec_out
);

  typedef enum logic [1:0] {COLLECT, COMPUTE, FLUSH, DRAIN} state_t;

  state_t              state;
  logic [3:0]          count;
  logic [2:0]          row;
  logic [2:0]          k;
  logic [BitWidth-1:0] xbuf [InLen];
  logic [4*OutLen-1:0] wmem [OutLen];
  logic [BitWidth-1:0] ybuf [OutLen];
  logic [BitWidth-1:0] y_cap;

`ifdef SEQ_RELU_EN
  assign y_cap = m_vec_out[BitWidth-1] ? '0 : m_vec_out;
`else
  assign y_cap = m_vec_out;
`endif

  // The multiplier only sees operands during COMPUTE; FLUSH feeds zeros while it drains.
  assign m_row    = m_en ? row : 3'd0;
  assign m_vec    = (state == COMPUTE) ? {xbuf[{row, 1'b1}], xbuf[{row, 1'b0}]} : '0;
  assign m_w      = (state == COMPUTE) ? wmem[row] : '0;
  assign out_data = ybuf[k];

  always_ff @(posedge clk) begin
    w_drop <= 1'b0;
    if (rst) begin
      state     <= COLLECT;
      count     <= 4'd0;
      row       <= 3'd0;
      k         <= 3'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      m_en      <= 1'b0;
      for (int i = 0; i < InLen; i++) xbuf[i] <= '0;
      for (int i = 0; i < OutLen; i++) begin
        wmem[i] <= '0;
        ybuf[i] <= '0;
      end
    end else begin
      if (w_load_en) begin
        if (state != COLLECT) w_drop <= 1'b1;
        else if (w_load_addr != 3'd7) wmem[w_load_addr] <= w_load_data;
      end
      case (state)
        COLLECT: begin
          if (in_valid && in_ready) begin
            xbuf[count] <= in_data;
            if (count == 4'(InLen - 1)) begin
              count    <= 4'd0;
              row      <= 3'd0;
              state    <= COMPUTE;
              in_ready <= 1'b0;
              busy     <= 1'b1;
              m_en     <= 1'b1;
            end else begin
              count <= count + 4'd1;
            end
          end
        end
        COMPUTE: begin
          if (row == 3'(OutLen - 1)) begin
            row   <= 3'd0;
            state <= FLUSH;
          end else begin
            row <= row + 3'd1;
          end
        end
        FLUSH: begin
          ybuf[row] <= y_cap;
          if (row == 3'(OutLen - 1)) begin
            row       <= 3'd0;
            k         <= 3'd0;
            state     <= DRAIN;
            m_en      <= 1'b0;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
          end else begin
            row <= row + 3'd1;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (k == 3'(OutLen - 1)) begin
              k         <= 3'd0;
              state     <= COLLECT;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
            end else begin
              k        <= k + 3'd1;
              out_last <= (k == 3'(OutLen - 2));
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_um_mult_seq.sv
// Self-checking bench for tt_um_mult_seq with a behavioural stand-in for the tt_um_mult multiplier.
// Build with +define+SEQ_RELU_EN to check the ReLU variant.
module tb_tt_um_mult_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        w_load_en = 1'b0;
  logic [2:0]  w_load_addr = 3'd0;
  logic [27:0] w_load_data = 28'd0;
  logic        w_drop;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        out_last;
  logic        busy;
  logic        m_en;
  logic [2:0]  m_row;
  logic [15:0] m_vec;
  logic [27:0] m_w;
  logic [7:0]  m_vec_out;

  int checks = 0;
  int failures = 0;

  logic [27:0] tw [7];
  logic [7:0]  tx [14];
  logic [7:0]  got_data [7];
  logic        got_last [7];
  logic        send_ok, drain_ok, overlap;

  tt_um_mult_seq dut (
    .clk(clk), .rst(rst),
    .w_load_en(w_load_en), .w_load_addr(w_load_addr), .w_load_data(w_load_data), .w_drop(w_drop),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .m_en(m_en), .m_row(m_row), .m_vec(m_vec), .m_w(m_w), .m_vec_out(m_vec_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int wval(logic [1:0] code);
    case (code)
      2'b01:   return 1;
      2'b11:   return -1;
      default: return 0;
    endcase
  endfunction

  function automatic int sx(logic [7:0] v);
    return int'($signed(v));
  endfunction

  // Reference result straight from the arithmetic definition of y[c].
  function automatic logic [7:0] ref_y(int c);
    int s = 0;
    logic [31:0] su;
    logic [7:0] y;
    for (int r = 0; r < 7; r++)
      s += wval(tw[r][2*c +: 2]) * sx(tx[2*r]) + wval(tw[r][14 + 2*c +: 2]) * sx(tx[2*r+1]);
    su = 32'(s);
    y = su[7:0];
`ifdef SEQ_RELU_EN
    if (y[7]) y = 8'h00;
`endif
    return y;
  endfunction

  // Stand-in multiplier: accumulates 7 rows, then returns column sums by row during the flush pass.
  int macc [7];
  int mstep = 0;
  always @(posedge clk) begin
    if (rst) begin
      mstep <= 0;
      for (int c = 0; c < 7; c++) macc[c] <= 0;
    end else if (m_en) begin
      if (mstep < 7)
        for (int c = 0; c < 7; c++)
          macc[c] <= macc[c] + wval(m_w[2*c +: 2]) * sx(m_vec[7:0])
                             + wval(m_w[14 + 2*c +: 2]) * sx(m_vec[15:8]);
      if (mstep == 13) begin
        mstep <= 0;
        for (int c = 0; c < 7; c++) macc[c] <= 0;
      end else begin
        mstep <= mstep + 1;
      end
    end
  end

  function automatic logic [7:0] mult_out(int step, logic [2:0] r);
    logic [31:0] v;
    if (step < 7 || r > 3'd6) return 8'h00;
    v = 32'(macc[r]);
    return v[7:0];
  endfunction
  assign m_vec_out = mult_out(mstep, m_row);

  // Driver helpers; all driving and sampling happens on the falling edge.
  task automatic load_weights();
    for (int a = 0; a < 7; a++) begin
      w_load_en = 1'b1; w_load_addr = 3'(a); w_load_data = tw[a];
      @(negedge clk);
    end
    w_load_en = 1'b0;
  endtask

  task automatic send_vector();
    int n;
    send_ok = 1'b1;
    for (int i = 0; i < 14; i++) begin
      in_valid = 1'b1; in_data = tx[i]; n = 0;
      while (!in_ready && n < 200) begin @(negedge clk); n++; end
      if (!in_ready) send_ok = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // Counts rising edges after the last input handshake until out_valid shows.
  task automatic wait_valid(output int lat);
    lat = 0; overlap = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) overlap = 1'b1;
      @(negedge clk); lat++;
    end
    if (out_valid && in_ready) overlap = 1'b1;
  endtask

  task automatic drain(input int mode);
    int n = 0;
    int j = 0;
    drain_ok = 1'b1;
    while (j < 7 && n < 400) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (out_valid && out_ready) begin
        got_data[j] = out_data; got_last[j] = out_last; j++;
      end
      @(negedge clk); n++;
    end
    out_ready = 1'b0;
    if (j < 7) drain_ok = 1'b0;
  endtask

  task automatic randomize_weights();
    for (int a = 0; a < 7; a++) tw[a] = 28'($urandom);
  endtask

  task automatic randomize_vector();
    for (int i = 0; i < 14; i++) tx[i] = 8'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (m_en !== 1'b0) begin failures++; $display("[TB] FAIL reset_m_en: got %b want 0", m_en); end
    checks++; if (m_row !== 3'd0) begin failures++; $display("[TB] FAIL reset_m_row: got %0d want 0", m_row); end
    checks++; if (out_data !== 8'h00 || w_drop !== 1'b0 || out_last !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_misc: out_data=%h w_drop=%b out_last=%b want 0", out_data, w_drop, out_last);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_all_plus_one();
    int lat;
    for (int a = 0; a < 7; a++) tw[a] = 28'h555_5555;
    for (int i = 0; i < 14; i++) tx[i] = 8'd1;
    load_weights();
    send_vector();
    // Stray input while busy must be ignored.
    in_valid = 1'b1; in_data = 8'hA5;
    wait_valid(lat);
    in_valid = 1'b0;
    // Handshake cycle T, out_valid in cycle T+15: 14 rising edges after the accepting edge.
    checks++; if (lat !== 14) begin failures++; $display("[TB] FAIL plus_latency: got %0d edges want 14", lat); end
    checks++; if (overlap !== 1'b0) begin failures++; $display("[TB] FAIL plus_in_ready_busy: in_ready seen high while busy"); end
    drain(0);
    checks++; if (!send_ok || !drain_ok) begin failures++; $display("[TB] FAIL plus_handshake_timeout: send=%b drain=%b want 1/1", send_ok, drain_ok); end
    for (int j = 0; j < 7; j++) begin
      checks++; if (got_data[j] !== 8'h0E) begin failures++; $display("[TB] FAIL plus_y%0d: got %h want 0e", j, got_data[j]); end
      checks++; if (got_last[j] !== (j == 6)) begin failures++; $display("[TB] FAIL plus_last%0d: got %b want %b", j, got_last[j], j == 6); end
    end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL plus_in_ready_after: got %b want 1", in_ready); end
  endtask

  task automatic test_all_minus_one();
    logic [7:0] want;
    for (int a = 0; a < 7; a++) tw[a] = 28'hFFF_FFFF;
    load_weights();
    for (int pass = 0; pass < 2; pass++) begin
      int lat;
      for (int i = 0; i < 14; i++) tx[i] = (pass == 0) ? 8'd5 : 8'd10;
`ifdef SEQ_RELU_EN
      want = (pass == 0) ? 8'h00 : 8'h74;
`else
      want = (pass == 0) ? 8'hBA : 8'h74;
`endif
      send_vector();
      wait_valid(lat);
      drain(2);
      checks++; if (!drain_ok) begin failures++; $display("[TB] FAIL minus_drain_timeout pass %0d", pass); end
      for (int j = 0; j < 7; j++) begin
        checks++; if (got_data[j] !== want) begin failures++; $display("[TB] FAIL minus_p%0d_y%0d: got %h want %h", pass, j, got_data[j], want); end
      end
    end
  endtask

  task automatic test_single_weight_and_drop();
    int lat;
    for (int a = 0; a < 7; a++) tw[a] = 28'h0;
    tw[3] = 28'h000_0001;
    for (int i = 0; i < 14; i++) tx[i] = 8'(i);
    load_weights();
    // Address 7 writes are discarded.
    w_load_en = 1'b1; w_load_addr = 3'd7; w_load_data = 28'hFFF_FFFF;
    @(negedge clk);
    w_load_en = 1'b0;
    checks++; if (w_drop !== 1'b0) begin failures++; $display("[TB] FAIL drop_in_collect: got %b want 0", w_drop); end
    send_vector();
    w_load_en = 1'b1; w_load_addr = 3'd3; w_load_data = 28'hFFF_FFFF;
    @(negedge clk);
    w_load_en = 1'b0;
    checks++; if (w_drop !== 1'b1) begin failures++; $display("[TB] FAIL drop_pulse: got %b want 1", w_drop); end
    @(negedge clk);
    checks++; if (w_drop !== 1'b0) begin failures++; $display("[TB] FAIL drop_pulse_end: got %b want 0", w_drop); end
    wait_valid(lat);
    drain(0);
    for (int j = 0; j < 7; j++) begin
      checks++; if (got_data[j] !== ((j == 0) ? 8'd6 : 8'd0)) begin
        failures++; $display("[TB] FAIL single_y%0d: got %h want %h", j, got_data[j], (j == 0) ? 8'd6 : 8'd0);
      end
    end
    // A second pass proves the dropped write never reached the weight store.
    send_vector();
    wait_valid(lat);
    drain(0);
    checks++; if (got_data[0] !== 8'd6) begin failures++; $display("[TB] FAIL single_after_drop_y0: got %h want 06", got_data[0]); end
  endtask

  task automatic test_drain_stall();
    int lat;
    logic [7:0] y0;
    randomize_weights();
    randomize_vector();
    load_weights();
    send_vector();
    wait_valid(lat);
    y0 = ref_y(0);
    out_ready = 1'b0;
    for (int n = 0; n < 20; n++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== y0) begin
        failures++; $display("[TB] FAIL stall_hold_%0d: valid=%b data=%h want 1/%h", n, out_valid, out_data, y0);
      end
      @(negedge clk);
    end
    drain(1);
    checks++; if (!drain_ok) begin failures++; $display("[TB] FAIL stall_drain_timeout"); end
    for (int j = 0; j < 7; j++) begin
      checks++; if (got_data[j] !== ref_y(j)) begin failures++; $display("[TB] FAIL stall_y%0d: got %h want %h", j, got_data[j], ref_y(j)); end
    end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL stall_in_ready_after: got %b want 1", in_ready); end
  endtask

  task automatic test_back_to_back();
    randomize_weights();
    load_weights();
    for (int v = 0; v < 5; v++) begin
      int lat;
      randomize_vector();
      send_vector();
      wait_valid(lat);
      checks++; if (lat !== 14 || overlap !== 1'b0) begin
        failures++; $display("[TB] FAIL b2b_v%0d_timing: lat=%0d overlap=%b want 14/0", v, lat, overlap);
      end
      drain(2);
      for (int j = 0; j < 7; j++) begin
        checks++; if (got_data[j] !== ref_y(j) || got_last[j] !== (j == 6)) begin
          failures++; $display("[TB] FAIL b2b_v%0d_y%0d: got %h/%b want %h/%b", v, j, got_data[j], got_last[j], ref_y(j), j == 6);
        end
      end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_v%0d_in_ready: got %b want 1", v, in_ready); end
    end
  endtask

  task automatic test_reset_in_flush();
    int lat;
    randomize_weights();
    randomize_vector();
    load_weights();
    send_vector();
    repeat (10) @(negedge clk);
    checks++; if (m_en !== 1'b1 || m_row !== 3'd3 || m_vec !== 16'h0 || m_w !== 28'h0) begin
      failures++; $display("[TB] FAIL flush_r3: m_en=%b m_row=%0d m_vec=%h m_w=%h want 1/3/0/0", m_en, m_row, m_vec, m_w);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || m_en !== 1'b0 || m_row !== 3'd0 || out_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL rst_flush_state: in_ready=%b busy=%b m_en=%b m_row=%0d out_valid=%b want 1/0/0/0/0",
                           in_ready, busy, m_en, m_row, out_valid);
    end
    for (int a = 0; a < 7; a++) tw[a] = 28'h0;
    randomize_vector();
    send_vector();
    wait_valid(lat);
    checks++; if (lat !== 14) begin failures++; $display("[TB] FAIL rst_fresh_latency: got %0d want 14", lat); end
    drain(0);
    for (int j = 0; j < 7; j++) begin
      checks++; if (got_data[j] !== 8'h00) begin failures++; $display("[TB] FAIL rst_zero_y%0d: got %h want 00", j, got_data[j]); end
    end
    randomize_weights();
    randomize_vector();
    load_weights();
    send_vector();
    wait_valid(lat);
    drain(2);
    for (int j = 0; j < 7; j++) begin
      checks++; if (got_data[j] !== ref_y(j)) begin failures++; $display("[TB] FAIL rst_realign_y%0d: got %h want %h", j, got_data[j], ref_y(j)); end
    end
  endtask

  initial begin
    test_reset();
    test_all_plus_one();
    test_all_minus_one();
    test_single_weight_and_drop();
    test_drain_stall();
    test_back_to_back();
    test_reset_in_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
